ldpc_sync_inserter: RTL

// Transmit-side LDPC framer. Takes 64-bit encoded codeword words from the LDPC encoder and emits a serial bit stream.

---
 rtl/ldpc_sync_inserter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_sync_inserter.sv
// Transmit-side LDPC framer: prefixes every codeword with its attached sync
// marker (1 word for k=1024, S,~S,S,S for k=4096) and serialises the frame
// MSB first, one bit per clkEn strobe, behind a one-word holding register.
module ldpc_sync_inserter #(
    parameter logic [63:0] SYNC_WORD = 64'hFCB8_8938_D8D7_6A4F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkEn,
    input  logic        codeLength4096,
    input  logic [1:0]  codeRate,
    input  logic        invertOutput,
    input  logic [63:0] payloadWord,
    input  logic        payloadValid,
    output logic        payloadReady,
    input  logic        clearUnderrun,
    output logic        dataBitOut,
    output logic        dataValid,
    output logic        frameStart,
    output logic        syncActive,
    output logic        underrun
);

    localparam logic [1:0] RATE_1_2 = 2'd0;
    localparam logic [1:0] RATE_2_3 = 2'd1;
    localparam logic [1:0] RATE_4_5 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_STALL
    } state_t;

    // Codeword length in 64-bit words; unknown rate codes fall back to 1/2.
    function automatic logic [7:0] frame_words(input logic [1:0] rate, input logic long_code);
        logic [7:0] w;
        case (rate)
            RATE_1_2: w = 8'd32;
            RATE_2_3: w = 8'd24;
            RATE_4_5: w = 8'd20;
            default:  w = 8'd32;
        endcase
        return long_code ? (w << 2) : w;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [63:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic        need_load_q, need_load_d;
    logic        long_q, long_d;
    logic [7:0]  wpf_q, wpf_d;
    logic        dout_q, dout_d;
    logic        dv_q, dv_d;
    logic        fs_q, fs_d;
    logic        sa_q, sa_d;
    logic        underrun_q, underrun_d;

    logic        accept;
    logic        emit;
    logic        emit_bit;
    logic        underrun_set;

    assign accept       = payloadValid & ~hold_full_q;
    assign payloadReady = ~hold_full_q & ~reset;

    assign dataBitOut = dout_q;
    assign dataValid  = dv_q;
    assign frameStart = fs_q;
    assign syncActive = sa_q;
    assign underrun   = underrun_q;

    // Next-state: input handshake every clk, framing FSM only on clkEn.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        need_load_d  = need_load_q;
        long_d       = long_q;
        wpf_d        = wpf_q;
        dout_d       = dout_q;
        dv_d         = 1'b0;
        fs_d         = 1'b0;
        sa_d         = 1'b0;
        emit         = 1'b0;
        emit_bit     = 1'b0;
        underrun_set = 1'b0;

        if (accept) begin
            hold_d      = payloadWord;
            hold_full_d = 1'b1;
        end

        if (clkEn) begin
            case (state_q)
                ST_IDLE: begin
                    // A held word means a whole frame can start; latch its mode now.
                    if (hold_full_q) begin
                        state_d    = ST_SYNC;
                        long_d     = codeLength4096;
                        wpf_d      = frame_words(codeRate, codeLength4096);
                        word_cnt_d = codeLength4096 ? 8'd3 : 8'd0;
                        bit_cnt_d  = 6'd62;
                        emit       = 1'b1;
                        emit_bit   = SYNC_WORD[63];
                        fs_d       = 1'b1;
                        sa_d       = 1'b1;
                    end
                end
                ST_SYNC: begin
                    // 4K marker is S,~S,S,S: the second word (word_cnt 2) is inverted.
                    emit      = 1'b1;
                    sa_d      = 1'b1;
                    emit_bit  = SYNC_WORD[bit_cnt_q] ^ (long_q && (word_cnt_q == 8'd2));
                    bit_cnt_d = bit_cnt_q - 6'd1;
                    if (bit_cnt_q == 6'd0) begin
                        if (word_cnt_q == 8'd0) begin
                            state_d     = ST_PAYLOAD;
                            need_load_d = 1'b1;
                            word_cnt_d  = wpf_q;
                        end else begin
                            word_cnt_d = word_cnt_q - 8'd1;
                        end
                    end
                end
                ST_PAYLOAD, ST_STALL: begin
                    if (need_load_q) begin
                        if (hold_full_q) begin
                            state_d     = ST_PAYLOAD;
                            shift_d     = {hold_q[62:0], 1'b0};
                            hold_full_d = 1'b0;
                            emit        = 1'b1;
                            emit_bit    = hold_q[63];
                            bit_cnt_d   = 6'd62;
                            word_cnt_d  = word_cnt_q - 8'd1;
                            need_load_d = 1'b0;
                        end else if (state_q == ST_PAYLOAD) begin
                            // Only the first missed boundary flags the underrun.
                            state_d      = ST_STALL;
                            underrun_set = 1'b1;
                        end
                    end else begin
                        emit      = 1'b1;
                        emit_bit  = shift_q[63];
                        shift_d   = {shift_q[62:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 6'd1;
                        if (bit_cnt_q == 6'd0) begin
                            // Last bit of the frame: IDLE restarts at once if a word is held.
                            if (word_cnt_q == 8'd0) begin
                                state_d = ST_IDLE;
                            end else begin
                                need_load_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (emit) begin
            dv_d   = 1'b1;
            dout_d = emit_bit ^ invertOutput;
        end

        underrun_d = (underrun_q & ~clearUnderrun) | underrun_set;
    end

    // Control, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 6'd0;
            word_cnt_q  <= 8'd0;
            need_load_q <= 1'b0;
            long_q      <= 1'b0;
            wpf_q       <= 8'd0;
            dout_q      <= 1'b0;
            dv_q        <= 1'b0;
            fs_q        <= 1'b0;
            sa_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            need_load_q <= need_load_d;
            long_q      <= long_d;
            wpf_q       <= wpf_d;
            dout_q      <= dout_d;
            dv_q        <= dv_d;
            fs_q        <= fs_d;
            sa_q        <= sa_d;
            underrun_q  <= underrun_d;
        end
    end

    // Payload data registers; qualified by hold_full_q / need_load_q, so no reset.
    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

endmodule
